// File: rtl/sba_bus_arbiter.sv
// Round-robin arbiter sharing one single-outstanding system-bus port between NUM_REQ requesters.
// Optional response watchdog (error response plus drain of the late reply) enabled by SBA_ARB_TIMEOUT_EN.
module sba_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*2-1:0]            size_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              valid_o,
    output logic [NUM_REQ-1:0]              err_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            bus_req_o,
    output logic                            bus_we_o,
    output logic [ADDR_WIDTH-1:0]           bus_addr_o,
    output logic [DATA_WIDTH-1:0]           bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0]         bus_be_o,
    output logic [1:0]                      bus_size_o,
    input  logic                            bus_gnt_i,
    input  logic                            bus_valid_i,
    input  logic [DATA_WIDTH-1:0]           bus_rdata_i
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SEL_W    = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sba_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_RESP = 2'd2,
        DRAIN     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] scan_sel;
    logic [SEL_W-1:0] sel_next;
    logic             timeout;

`ifdef SBA_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;

    // Held at zero outside WaitResp, so every entry starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (state_q != WAIT_RESP) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // A real response in the limit cycle takes precedence over the timeout.
    assign timeout = (state_q == WAIT_RESP) && !bus_valid_i &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin : p_scan
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        scan_sel = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                scan_sel = SEL_W'(idx);
            end
        end
    end

    assign sel_next = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    sel_d   = scan_sel;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                // Once the bus grants, the transaction is committed downstream.
                if (bus_gnt_i) begin
                    state_d = WAIT_RESP;
                end else if (!req_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            WAIT_RESP: begin
                if (bus_valid_i || timeout) begin
                    rr_ptr_d = sel_next;
                    state_d  = bus_valid_i ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (bus_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = '0;
        valid_o     = '0;
        err_o       = '0;
        rdata_o     = '0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_be_o    = '0;
        bus_size_o  = '0;
        case (state_q)
            REQUEST: begin
                bus_req_o     = 1'b1;
                bus_we_o      = we_i[sel_q];
                bus_addr_o    = addr_i[int'(sel_q)*ADDR_WIDTH +: ADDR_WIDTH];
                bus_wdata_o   = wdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                bus_be_o      = be_i[int'(sel_q)*BE_WIDTH +: BE_WIDTH];
                bus_size_o    = size_i[int'(sel_q)*2 +: 2];
                gnt_o[sel_q]  = bus_gnt_i;
            end
            WAIT_RESP: begin
                if (bus_valid_i) begin
                    valid_o[sel_q] = 1'b1;
                    rdata_o        = bus_rdata_i;
                end else if (timeout) begin
                    valid_o[sel_q] = 1'b1;
                    err_o[sel_q]   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sba_bus_arbiter.sv
// Directed and randomized bench for sba_bus_arbiter with a transaction-level round-robin model.
module tb_sba_bus_arbiter;
    localparam int NR = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int TO = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [1:0]    size;
    } txn_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_i, we_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*DW-1:0]  wdata_i;
    logic [NR*BW-1:0]  be_i;
    logic [NR*2-1:0]   size_i;
    logic [NR-1:0]     gnt_o, valid_o, err_o;
    logic [DW-1:0]     rdata_o;
    logic              bus_req_o, bus_we_o;
    logic [AW-1:0]     bus_addr_o;
    logic [DW-1:0]     bus_wdata_o;
    logic [BW-1:0]     bus_be_o;
    logic [1:0]        bus_size_o;
    logic              bus_gnt_i, bus_valid_i;
    logic [DW-1:0]     bus_rdata_i;

    sba_bus_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .gnt_o(gnt_o), .valid_o(valid_o),
        .err_o(err_o), .rdata_o(rdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_size_o(bus_size_o), .bus_gnt_i(bus_gnt_i), .bus_valid_i(bus_valid_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    txn_t q [NR][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int r);
        return NR'(1) << r;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = {$urandom, $urandom};
        t.wdata = {$urandom, $urandom};
        t.be    = BW'($urandom);
        t.size  = 2'($urandom_range(0, 3));
        return t;
    endfunction

    // Next requester: first with pending work after the last one served, wrapping around.
    function automatic int pick(input int last);
        for (int i = 1; i <= NR; i++) begin
            if (q[(last + i) % NR].size() > 0) return (last + i) % NR;
        end
        return -1;
    endfunction

    task automatic set_txn(input int r, input txn_t t);
        we_i[r]              = t.we;
        addr_i[r*AW +: AW]   = t.addr;
        wdata_i[r*DW +: DW]  = t.wdata;
        be_i[r*BW +: BW]     = t.be;
        size_i[r*2 +: 2]     = t.size;
    endtask

    task automatic drive_from_queues();
        for (int r = 0; r < NR; r++) begin
            req_i[r] = (q[r].size() > 0);
            if (q[r].size() > 0) set_txn(r, q[r][0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
        bus_gnt_i   = 1'b0;
        bus_valid_i = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},   64'(gnt_o),     64'd0);
        chk({tag, "_valid"}, 64'(valid_o),   64'd0);
        chk({tag, "_err"},   64'(err_o),     64'd0);
        chk({tag, "_rdata"}, rdata_o,        64'd0);
        chk({tag, "_breq"},  64'(bus_req_o), 64'd0);
        chk({tag, "_bwe"},   64'(bus_we_o),  64'd0);
        chk({tag, "_baddr"}, bus_addr_o,     64'd0);
        chk({tag, "_bwdat"}, bus_wdata_o,    64'd0);
        chk({tag, "_bbe"},   64'(bus_be_o),  64'd0);
        chk({tag, "_bsize"}, 64'(bus_size_o), 64'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '1; we_i = '1; addr_i = '1; wdata_i = '1; be_i = '1; size_i = '1;
        bus_gnt_i = 1'b1; bus_valid_i = 1'b1; bus_rdata_i = '1;
        repeat (2) @(posedge clk_i);
        #1;
        chk_quiet("reset");
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0; size_i = '0;
        bus_gnt_i = 1'b0; bus_valid_i = 1'b0; bus_rdata_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Waits for bus_req_o (bounded), checks muxed fields, grants after gdly cycles.
    task automatic arb_grant(input int r, input txn_t t, input int gdly, output int idle);
        bit found;
        found = 1'b0;
        idle  = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            cyc();
            if (bus_req_o) begin
                found = 1'b1;
            end else begin
                bus_gnt_i   = 1'($urandom_range(0, 1));
                bus_valid_i = 1'($urandom_range(0, 1));
                bus_rdata_i = {$urandom, $urandom};
                #1;
                chk("idle_gnt",   64'(gnt_o),    64'd0);
                chk("idle_valid", 64'(valid_o),  64'd0);
                chk("idle_rdata", rdata_o,       64'd0);
                chk("idle_be",    64'(bus_be_o), 64'd0);
                chk("idle_addr",  bus_addr_o,    64'd0);
                idle++;
            end
        end
        if (!found) begin
            chk("bus_req_seen", 64'd0, 64'd1);
            return;
        end
        for (int k = 0; k <= gdly; k++) begin
            if (k > 0) cyc();
            bus_gnt_i   = (k == gdly);
            bus_valid_i = 1'($urandom_range(0, 1));
            bus_rdata_i = {$urandom, $urandom};
            #1;
            chk("req_hi",    64'(bus_req_o),  64'd1);
            chk("bus_we",    64'(bus_we_o),   64'(t.we));
            chk("bus_addr",  bus_addr_o,      t.addr);
            chk("bus_wdata", bus_wdata_o,     t.wdata);
            chk("bus_be",    64'(bus_be_o),   64'(t.be));
            chk("bus_size",  64'(bus_size_o), 64'(t.size));
            chk("gnt",       64'(gnt_o),      (k == gdly) ? 64'(oh(r)) : 64'd0);
            chk("req_valid", 64'(valid_o),    64'd0);
            chk("req_rdata", rdata_o,         64'd0);
        end
    endtask

    task automatic respond(input int r, input int rdly, input logic [DW-1:0] rd);
        for (int k = 1; k <= rdly; k++) begin
            cyc();
            bus_gnt_i   = 1'($urandom_range(0, 1));
            bus_valid_i = (k == rdly);
            bus_rdata_i = (k == rdly) ? rd : {$urandom, $urandom};
            #1;
            chk("wait_breq",  64'(bus_req_o), 64'd0);
            chk("wait_baddr", bus_addr_o,     64'd0);
            chk("wait_gnt",   64'(gnt_o),     64'd0);
            chk("wait_err",   64'(err_o),     64'd0);
            chk("resp_valid", 64'(valid_o),   (k == rdly) ? 64'(oh(r)) : 64'd0);
            chk("resp_rdata", rdata_o,        (k == rdly) ? rd : 64'd0);
        end
    endtask

    task automatic serve(input int r, input txn_t t, input int gdly, input int rdly,
                         input logic [DW-1:0] rd, output int idle);
        arb_grant(r, t, gdly, idle);
        respond(r, rdly, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        txn_t t0, t1, tw;
        int   idle, last, total, exp_r;

        // Reset values, then single-requester read with exact cycle timing.
        do_reset();
        t0 = '0; t0.addr = 64'h8000_0010; t0.size = 2'd3; t0.be = '1;
        set_txn(0, t0); req_i = 3'b001;
        #1; chk("cycle0_breq", 64'(bus_req_o), 64'd0);
        serve(0, t0, 2, 3, 64'hDEAD_BEEF, idle);
        chk("req_latency", 64'(idle), 64'd0);
        req_i = '0;

        // Round robin with two requesters held continuously.
        do_reset();
        t0 = rand_txn(); t1 = rand_txn();
        set_txn(0, t0); set_txn(1, t1); req_i = 3'b011;
        for (int i = 0; i < 4; i++) begin
            serve(i % 2, (i % 2 == 0) ? t0 : t1, 0, 2, {$urandom, $urandom}, idle);
            if (i > 0) chk("rr_gap", 64'(idle), 64'd1);
        end
        req_i = '0;

        // Write muxing from requester 1.
        tw = '0; tw.we = 1'b1; tw.addr = 64'h1008; tw.wdata = 64'h55AA; tw.be = 8'hF0; tw.size = 2'd2;
        set_txn(1, tw); req_i = 3'b010;
        serve(1, tw, 1, 1, 64'h1234, idle);
        chk("wr_gap", 64'(idle), 64'd1);
        req_i = '0;

        // Abort: requester 0 withdraws before grant.
        do_reset();
        t0 = rand_txn(); t1 = rand_txn();
        set_txn(0, t0); req_i = 3'b001;
        cyc(); #1; chk("abort_req1", 64'(bus_req_o), 64'd1);
        cyc(); req_i = 3'b000; #1;
        chk("abort_req2", 64'(bus_req_o), 64'd1);
        chk("abort_gnt", 64'(gnt_o), 64'd0);
        cyc(); #1;
        chk("abort_idle", 64'(bus_req_o), 64'd0);
        chk("abort_valid", 64'(valid_o), 64'd0);
        set_txn(1, t1); req_i = 3'b011;
        serve(0, t0, 0, 1, {$urandom, $urandom}, idle);
        req_i = '0;

        // Asynchronous reset while waiting for a response.
        t0 = rand_txn();
        set_txn(0, t0); req_i = 3'b001;
        arb_grant(0, t0, 0, idle);
        cyc(); bus_valid_i = 1'b1; bus_rdata_i = 64'hCAFE_F00D; #1;
        chk("pre_rst_valid", 64'(valid_o), 64'(oh(0)));
        rst_ni = 1'b0;
        #1; chk_quiet("async_rst");
        req_i = '0; bus_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_ni = 1'b1;
        t1 = rand_txn(); set_txn(1, t1); req_i = 3'b010;
        serve(1, t1, 1, 2, {$urandom, $urandom}, idle);
        req_i = '0;

`ifdef SBA_ARB_TIMEOUT_EN
        // Response in the limit cycle wins over the watchdog.
        t0 = rand_txn(); set_txn(0, t0); req_i = 3'b001;
        serve(0, t0, 0, TO, {$urandom, $urandom}, idle);
        // Withheld response: error at WaitResp cycle TO, late reply swallowed.
        arb_grant(0, t0, 0, idle);
        req_i = '0;
        for (int k = 1; k <= TO; k++) begin
            cyc(); bus_rdata_i = {$urandom, $urandom} | 64'd1; #1;
            chk("to_valid", 64'(valid_o), (k == TO) ? 64'(oh(0)) : 64'd0);
            chk("to_err",   64'(err_o),   (k == TO) ? 64'(oh(0)) : 64'd0);
            chk("to_rdata", rdata_o,      64'd0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); bus_rdata_i = {$urandom, $urandom}; #1;
            chk_quiet("drain");
        end
        cyc(); bus_valid_i = 1'b1; bus_rdata_i = 64'hBAD0_BAD0; #1;
        chk("drain_valid", 64'(valid_o), 64'd0);
        chk("drain_rdata", rdata_o, 64'd0);
        t1 = rand_txn(); set_txn(0, t0); set_txn(1, t1); req_i = 3'b011;
        serve(1, t1, 0, 1, {$urandom, $urandom}, idle);
        chk("drain_gap", 64'(idle), 64'd1);
        req_i = '0;
`else
        // Without the watchdog a slow response is simply waited for.
        t0 = rand_txn(); set_txn(0, t0); req_i = 3'b001;
        serve(0, t0, 0, TO + 4, {$urandom, $urandom}, idle);
        req_i = '0;
`endif

        // Randomized traffic against the transaction-level model.
        do_reset();
        last = NR - 1;
        for (int rnd = 0; rnd < 6; rnd++) begin
            total = 0;
            for (int r = 0; r < NR; r++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++) q[r].push_back(rand_txn());
                total += n;
            end
            if (total == 0) begin
                q[$urandom_range(0, NR - 1)].push_back(rand_txn());
                total = 1;
            end
            drive_from_queues();
            for (int x = 0; x < total; x++) begin
                exp_r = pick(last);
                serve(exp_r, q[exp_r][0], $urandom_range(0, 3), $urandom_range(1, 4),
                      {$urandom, $urandom}, idle);
                if (x > 0) chk("rand_gap", 64'(idle), 64'd1);
                void'(q[exp_r].pop_front());
                last = exp_r;
                drive_from_queues();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
